// File: rtl/i2c_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// Optional SCL clock stretching when I2C_MASTER_CLK_STRETCH_EN is defined.
module i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, RW, ADDR_ACK, DATA, DATA_ACK, STOP
  } state_t;

  localparam int CW = $clog2(CLK_DIV);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_q;
  logic [2:0]      r_bit;
  logic            r_rw;
  logic [7:0]      r_tx;
  logic [7:0]      r_wdata;
  logic [7:0]      r_shift;
  logic [7:0]      r_rdata;
  logic            r_busy;
  logic            r_done;
  logic            r_ack_err;
  logic            r_scl_oe;
  logic            r_sda_oe;
  logic            w_stall;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // A slave holding SCL low after we release it freezes the bit timing.
  assign w_stall = (r_state != IDLE) && (r_q == 2'd1) && !scl_i;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_stall      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_q       <= 2'd0;
      r_bit     <= 3'd0;
      r_rw      <= 1'b0;
      r_tx      <= 8'h00;
      r_wdata   <= 8'h00;
      r_shift   <= 8'h00;
      r_rdata   <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        r_q   <= 2'd0;
        r_bit <= 3'd0;
        if (start) begin
          r_state   <= START;
          r_busy    <= 1'b1;
          r_ack_err <= 1'b0;
          r_rw      <= rw;
          r_tx      <= {addr, rw};
          r_wdata   <= wdata;
        end
      end else if (!w_stall) begin
        if (r_cnt != CW'(CLK_DIV - 1)) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
          r_q   <= r_q + 2'd1;
          case (r_q)
            2'd0: begin
              r_scl_oe <= 1'b0;
              if (r_state == START) r_sda_oe <= 1'b1;
            end
            2'd1: begin
              // Entering Q2: SCL has been high for a quarter, sample SDA.
              if (r_state == ADDR_ACK && sda_i) r_ack_err <= 1'b1;
              if (r_state == DATA_ACK && !r_rw && sda_i) r_ack_err <= 1'b1;
              if (r_state == DATA && r_rw) r_shift <= {r_shift[6:0], sda_i};
            end
            2'd2: begin
              if (r_state == STOP) r_sda_oe <= 1'b0;
              else                 r_scl_oe <= 1'b1;
            end
            default: begin
              r_scl_oe <= 1'b1;
              r_bit    <= r_bit + 3'd1;
              case (r_state)
                START: begin
                  r_state  <= ADDR;
                  r_bit    <= 3'd0;
                  r_sda_oe <= ~r_tx[7];
                  r_tx     <= {r_tx[6:0], 1'b0};
                end
                ADDR: begin
                  r_sda_oe <= ~r_tx[7];
                  r_tx     <= {r_tx[6:0], 1'b0};
                  if (r_bit == 3'd6) r_state <= RW;
                end
                RW: begin
                  r_state  <= ADDR_ACK;
                  r_sda_oe <= 1'b0;
                  r_tx     <= r_wdata;
                end
                ADDR_ACK: begin
                  r_bit <= 3'd0;
                  if (r_ack_err) begin
                    r_state  <= STOP;
                    r_sda_oe <= 1'b1;
                  end else begin
                    r_state <= DATA;
                    if (r_rw) begin
                      r_sda_oe <= 1'b0;
                    end else begin
                      r_sda_oe <= ~r_tx[7];
                      r_tx     <= {r_tx[6:0], 1'b0};
                    end
                  end
                end
                DATA: begin
                  if (r_bit == 3'd7) begin
                    r_state  <= DATA_ACK;
                    r_sda_oe <= 1'b0;
                    if (r_rw) r_rdata <= r_shift;
                  end else if (!r_rw) begin
                    r_sda_oe <= ~r_tx[7];
                    r_tx     <= {r_tx[6:0], 1'b0};
                  end
                end
                DATA_ACK: begin
                  r_state  <= STOP;
                  r_sda_oe <= 1'b1;
                end
                STOP: begin
                  r_state  <= IDLE;
                  r_scl_oe <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                end
                default: r_state <= IDLE;
              endcase
            end
          endcase
        end
      end
    end
  end

  assign rdata   = r_rdata;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign scl_oe  = r_scl_oe;
  assign sda_oe  = r_sda_oe;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with CLK_DIV=4 (16 clocks per bit) and a timed slave model.
module tb_i2c_master;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       busy, done, ack_err, scl_oe, sda_oe, scl_i, sda_i;
  logic       stretch, slave_low;
  logic       s_rw, s_ack_addr, s_ack_data;
  logic [7:0] s_byte;

  int cyc = 0;
  int t0 = -100000;
  int n_checks = 0;
  int n_fail = 0;

  logic       scl_log  [0:399];
  logic       sda_log  [0:399];
  logic       bus_log  [0:399];
  logic       done_log [0:399];
  logic       busy_log [0:399];
  logic       err_log  [0:399];
  logic [7:0] rd_log   [0:399];

  i2c_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave behaviour keyed to bit slot t/16 counted from the start-accept edge.
  function automatic logic slave_pull(input int t, input logic r, input logic aa,
                                      input logic ad, input logic [7:0] sb);
    int b;
    b = t / 16;
    slave_pull = 1'b0;
    if (t >= 0) begin
      if (b == 9) slave_pull = aa;
      else if (r && aa && b >= 10 && b <= 17) slave_pull = ~sb[3'(17 - b)];
      else if (!r && b == 18) slave_pull = ad;
    end
  endfunction

  assign slave_low = slave_pull(cyc - t0, s_rw, s_ack_addr, s_ack_data, s_byte);
  assign sda_i     = ~sda_oe & ~slave_low;
  assign scl_i     = ~scl_oe & ~stretch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic log_at(input int k);
    scl_log[k]  = scl_oe;
    sda_log[k]  = sda_oe;
    bus_log[k]  = sda_i;
    done_log[k] = done;
    busy_log[k] = busy;
    err_log[k]  = ack_err;
    rd_log[k]   = rdata;
  endtask

  task automatic txn(input logic r, input logic [6:0] a, input logic [7:0] wd,
                     input logic aa, input logic ad, input logic [7:0] sb,
                     input int n, input int inj_at, input int str_at);
    @(negedge clk);
    s_rw = r; s_ack_addr = aa; s_ack_data = ad; s_byte = sb;
    start = 1'b1; rw = r; addr = a; wdata = wd;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    log_at(0);
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
      if (k == inj_at)     begin start = 1'b1; addr = 7'h55; rw = 1'b1; wdata = 8'hFF; end
      if (k == inj_at + 1) start = 1'b0;
      if (k == str_at)      stretch = 1'b1;
      if (k == str_at + 10) stretch = 1'b0;
      log_at(k);
    end
  endtask

  function automatic int first_done(input int n);
    first_done = -1;
    for (int k = n - 1; k >= 0; k--) if (done_log[k]) first_done = k;
  endfunction

  function automatic int count_done(input int n);
    count_done = 0;
    for (int k = 0; k < n; k++) if (done_log[k]) count_done++;
  endfunction

  function automatic logic [7:0] bus_byte(input int first_bit);
    for (int i = 0; i < 8; i++) bus_byte[7 - i] = bus_log[(first_bit + i) * 16 + 9];
  endfunction

  function automatic logic [1:0] pins(input int k);
    pins = {scl_log[k], sda_log[k]};
  endfunction

  initial begin
    int n_act;
    rst_n = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
    stretch = 1'b0; s_rw = 1'b0; s_ack_addr = 1'b0; s_ack_data = 1'b0; s_byte = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pins",  32'({scl_oe, sda_oe}), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(ack_err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Write 0x08 <- 0xA5, slave ACKs both bytes
    txn(1'b0, 7'h08, 8'hA5, 1'b1, 1'b1, 8'h00, 340, -1, -1);
    chk("wr_busy_t0",  32'(busy_log[0]), 1);
    chk("wr_start_q0", 32'(pins(1)), 'b00);
    chk("wr_start_q1", 32'(pins(5)), 'b01);
    chk("wr_start_q3", 32'(pins(13)), 'b11);
    chk("wr_addr",     32'(bus_byte(1)), 'h10);
    chk("wr_aack_rel", 32'(sda_log[153]), 0);
    chk("wr_data",     32'(bus_byte(10)), 'hA5);
    chk("wr_stop_q0",  32'(pins(305)), 'b11);
    chk("wr_stop_q1",  32'(pins(309)), 'b01);
    chk("wr_stop_q3",  32'(pins(317)), 'b00);
    chk("wr_done_at",  32'(first_done(340)), 320);
    chk("wr_done_cnt", 32'(count_done(340)), 1);
    chk("wr_busy_end", 32'({busy_log[319], busy_log[320]}), 'b10);
    chk("wr_err",      32'(err_log[320]), 0);
    chk("wr_rdata",    32'(rd_log[320]), 0);

    // Read 0x08, slave returns 0x3C
    txn(1'b1, 7'h08, 8'h00, 1'b1, 1'b0, 8'h3C, 340, -1, -1);
    chk("rd_addr", 32'(bus_byte(1)), 'h11);
    chk("rd_bus",  32'(bus_byte(10)), 'h3C);
    n_act = 0;
    for (int k = 160; k < 304; k++) if (sda_log[k]) n_act++;
    chk("rd_master_released", 32'(n_act), 0);
    chk("rd_nack_bus",   32'(bus_log[18 * 16 + 9]), 1);
    chk("rd_rdata_pre",  32'(rd_log[287]), 0);
    chk("rd_rdata_load", 32'(rd_log[288]), 'h3C);
    chk("rd_done_at",    32'(first_done(340)), 320);
    chk("rd_err",        32'(err_log[320]), 0);

    // Start pulsed with addr 0x55 while busy must be ignored
    txn(1'b0, 7'h08, 8'h5A, 1'b1, 1'b1, 8'h00, 340, 50, -1);
    chk("bz_addr",     32'(bus_byte(1)), 'h10);
    chk("bz_data",     32'(bus_byte(10)), 'h5A);
    chk("bz_done_at",  32'(first_done(340)), 320);
    chk("bz_done_cnt", 32'(count_done(340)), 1);
    chk("bz_idle",     32'(busy_log[339]), 0);
    chk("bz_rdata",    32'(rd_log[339]), 'h3C);

    // Write with no slave: address NACK, straight to STOP
    txn(1'b0, 7'h08, 8'hFF, 1'b0, 1'b0, 8'h00, 200, -1, -1);
    chk("na_err_pre",  32'(err_log[151]), 0);
    chk("na_err_smp",  32'(err_log[152]), 1);
    chk("na_stop_q0",  32'(pins(161)), 'b11);
    chk("na_stop_q2",  32'(pins(169)), 'b01);
    chk("na_stop_q3",  32'(pins(173)), 'b00);
    chk("na_done_at",  32'(first_done(200)), 176);
    chk("na_err_done", 32'(err_log[176]), 1);
    chk("na_rdata",    32'(rd_log[199]), 'h3C);

    // Read with no slave: rdata must stay
    txn(1'b1, 7'h08, 8'h00, 1'b0, 1'b0, 8'hFF, 200, -1, -1);
    chk("nr_done_at", 32'(first_done(200)), 176);
    chk("nr_err",     32'(err_log[176]), 1);
    chk("nr_rdata",   32'(rd_log[199]), 'h3C);

    // Write where slave NACKs the data byte
    txn(1'b0, 7'h08, 8'h3C, 1'b1, 1'b0, 8'h00, 340, -1, -1);
    chk("dn_err_clr", 32'(err_log[0]), 0);
    chk("dn_done_at", 32'(first_done(340)), 320);
    chk("dn_err",     32'(err_log[320]), 1);

    // Reset in DATA bit 3 (wdata 0x00 so both lines are pulled)
    txn(1'b0, 7'h08, 8'h00, 1'b1, 1'b1, 8'h00, 210, -1, -1);
    chk("mr_pins_pre", 32'({scl_oe, sda_oe, busy}), 'b111);
    rst_n = 1'b0;
    #1;
    chk("mr_pins",  32'({scl_oe, sda_oe}), 'b00);
    chk("mr_busy",  32'(busy), 0);
    chk("mr_rdata", 32'(rdata), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    n_act = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (done || busy || scl_oe || sda_oe) n_act++;
    end
    chk("mr_no_resume", 32'(n_act), 0);

    txn(1'b0, 7'h08, 8'hFF, 1'b0, 1'b0, 8'h00, 200, -1, -1);
    chk("fr_done_at", 32'(first_done(200)), 176);

`ifdef I2C_MASTER_CLK_STRETCH_EN
    // SCL held low 10 clocks in Q1 of ADDR bit 2
    txn(1'b0, 7'h08, 8'hFF, 1'b0, 1'b0, 8'h00, 220, -1, 52);
    chk("st_done_at", 32'(first_done(220)), 186);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250, meaning clk cycles per SCL quarter-period (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port rw  input  1  0=write byte, 1=read byte; captured with start.
REQ-006 SHALL have port addr  input  7  target address; captured with start.
REQ-007 SHALL have port wdata  input  8  write byte; captured with start.
REQ-008 SHALL have port rdata  output  8  last byte read.
REQ-009 SHALL have port busy  output  1  transaction in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-011 SHALL have port ack_err  output  1  last transaction saw NACK; valid with done, held until next start.
REQ-012 SHALL have ports scl_oe and sda_oe  output  1 each  open-drain pull-low enables (1 = drive 0, 0 = release).
REQ-013 SHALL have ports scl_i and sda_i  input  1 each  sensed bus levels.

Function
REQ-014 SHALL contain a quarter-phase counter, 0..CLK_DIV-1; it wraps to 0, advancing one quarter per wrap.
REQ-015 SHALL split each bit into Q0..Q3: SCL low in Q0/Q3, released in Q1/Q2; SDA changes only at Q0 start; sda_i sampled at Q2 start.
REQ-016 SHALL use states IDLE, START, ADDR, RW, ADDR_ACK, DATA, DATA_ACK, STOP.
REQ-017 SHALL, in IDLE with start=1, capture rw/addr/wdata, clear ack_err, set busy the next cycle, and enter START.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL, in START (4 quarters), pull SDA low while SCL is released, then pull SCL low.
REQ-020 SHALL send addr MSB-first over 7 bits (ADDR), then rw (RW).
REQ-021 SHALL, in ADDR_ACK, release SDA; sda_i=1 at sample sets ack_err and goes to STOP, skipping DATA.
REQ-022 SHALL, on write, send wdata MSB-first; in DATA_ACK, release SDA; sda_i=1 at sample sets ack_err.
REQ-023 SHALL, on read, release SDA for 8 bits, shift sda_i MSB-first, load rdata at the end of bit 8, and drive NACK (release) in DATA_ACK.
REQ-024 SHALL, in STOP (4 quarters), pull SDA low, release SCL, then release SDA; it then enters IDLE, drops busy, and pulses done on that cycle.
REQ-025 SHALL take exactly 80*CLK_DIV cycles from the start-accept edge to done, or 44*CLK_DIV cycles on address NACK, with no clock stretching.
REQ-026 SHALL hold rdata unchanged on writes and on address-NACK reads.

Reset
REQ-027 SHALL, with rst_n=0, immediately set scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rdata=0x00, state=IDLE, counters=0, even mid-transaction.
REQ-028 SHALL require a fresh start after rst_n deasserts; an interrupted transaction is not resumed.

Configuration
REQ-029 SHALL honour macro I2C_MASTER_CLK_STRETCH_EN: when defined, the quarter counter freezes in Q1 while scl_i=0 after SCL is released, resuming once scl_i=1; when undefined, scl_i is ignored and timing is fixed per REQ-025.

Verification
REQ-030 SHALL cover: CLK_DIV=4, write addr=0x08, wdata=0xA5, slave ACKs -> SDA bits 0001000,0 then 10100101; ack_err=0; done at cycle 320.
REQ-031 SHALL cover: write addr=0x08, no slave -> ack_err=1; no data bits; STOP follows; done at cycle 176.
REQ-032 SHALL cover: read addr=0x08, slave drives 0x3C -> rdata=0x3C at done; master releases SDA in DATA_ACK.
REQ-033 SHALL cover: start pulsed while busy, with addr=0x55 -> ignored; the bus shows only the original transaction.
REQ-034 SHALL cover: rst_n low during DATA bit 3 -> scl_oe=sda_oe=0 and busy=0 the same instant; no done pulse.
REQ-035 SHALL cover: with I2C_MASTER_CLK_STRETCH_EN defined, slave holds scl_i low 10 cycles in ADDR bit 2 -> done delayed exactly 10 cycles.
